// File: rtl/rv_trap_seq.sv
// rv_trap_seq -- machine-mode trap sequencer.
//
// Sits between the core pipeline and the machine CSR file. In IDLE it
// arbitrates a synchronous exception, an MRET and the pending machine
// interrupts. On a trap it issues ordered single-cycle CSR writes
// (mepc, mcause, optional mtval, mstatus) and then redirects and flushes
// the pipeline to the trap vector. On an MRET it rewrites mstatus and then
// redirects to mepc.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_irq_*, i_en_*         interrupt pending levels and mie enables
//   i_mstatus, i_mepc       current CSR read values
//   i_trap_pc               trap vector computed by the CSR file
//   i_boundary              instruction boundary (interrupts may be taken)
//   i_exc_*                 synchronous exception request, cause, pc, tval
//   i_mret, i_next_pc       MRET retiring; interrupt return address
//   o_stall, o_busy         pipeline hold; sequencer active
//   o_flush, o_redirect(_pc) one-cycle pipeline redirect
//   o_csr_*                 full-word CSR write port
module rv_trap_seq #(
  parameter bit MTVAL_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_irq_ext,
  input  logic        i_irq_soft,
  input  logic        i_irq_timer,
  input  logic        i_en_ext,
  input  logic        i_en_soft,
  input  logic        i_en_timer,
  input  logic [31:0] i_mstatus,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_trap_pc,
  input  logic        i_boundary,
  input  logic        i_exc_valid,
  input  logic [3:0]  i_exc_code,
  input  logic [31:0] i_exc_pc,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret,
  input  logic [31:0] i_next_pc,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_csr_sel,
  output logic        o_csr_write,
  output logic [7:0]  o_csr_idx,
  output logic [31:0] o_csr_data,
  output logic        o_busy
);

  localparam logic [7:0] IDX_MSTATUS = 8'h00;
  localparam logic [7:0] IDX_MEPC    = 8'h41;
  localparam logic [7:0] IDX_MCAUSE  = 8'h42;
  localparam logic [7:0] IDX_MTVAL   = 8'h43;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR, R_STATUS, R_REDIR
  } state_t;

  state_t      state_q, state_d;
  logic        is_irq_q, is_irq_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;

  logic        irq_take;
  logic [3:0]  irq_code;
  logic        accept_trap;
  logic        accept_mret;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [31:0] entry_status(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <- MPIE, MPIE <- 1, MPP stays M (only mode implemented).
  function automatic logic [31:0] mret_status(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Request decode. Reset gates acceptance so the stall output stays low
  // while reset is asserted.
  always_comb begin
    irq_take = i_mstatus[3] & i_boundary &
               ((i_irq_ext & i_en_ext) | (i_irq_soft & i_en_soft) |
                (i_irq_timer & i_en_timer));
    if (i_irq_ext & i_en_ext) begin
      irq_code = 4'd11;
    end else if (i_irq_soft & i_en_soft) begin
      irq_code = 4'd3;
    end else begin
      irq_code = 4'd7;
    end
    accept_trap = ~i_reset & (state_q == IDLE) &
                  (i_exc_valid | (~i_mret & irq_take));
    accept_mret = ~i_reset & (state_q == IDLE) & ~i_exc_valid & i_mret;
  end

  // Next state and latched trap context.
  always_comb begin
    state_d  = state_q;
    is_irq_d = is_irq_q;
    code_d   = code_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    case (state_q)
      IDLE: begin
        if (accept_trap) begin
          state_d  = W_EPC;
          is_irq_d = ~i_exc_valid;
          code_d   = i_exc_valid ? i_exc_code : irq_code;
          epc_d    = i_exc_valid ? i_exc_pc : i_next_pc;
          tval_d   = i_exc_valid ? i_exc_tval : 32'h0;
        end else if (accept_mret) begin
          state_d = R_STATUS;
        end
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = MTVAL_EN ? W_TVAL : W_STATUS;
      W_TVAL:   state_d = W_STATUS;
      W_STATUS: state_d = REDIR;
      REDIR:    state_d = IDLE;
      R_STATUS: state_d = R_REDIR;
      R_REDIR:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are a pure function of state plus live CSR/vector inputs.
  always_comb begin
    o_busy        = (state_q != IDLE);
    o_stall       = o_busy | accept_trap | accept_mret;
    o_flush       = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'h0;
    o_csr_sel     = 1'b0;
    o_csr_write   = 1'b0;
    o_csr_idx     = 8'h00;
    o_csr_data    = 32'h0;
    case (state_q)
      W_EPC: begin
        o_csr_sel   = 1'b1;
        o_csr_write = 1'b1;
        o_csr_idx   = IDX_MEPC;
        o_csr_data  = epc_q;
      end
      W_CAUSE: begin
        o_csr_sel   = 1'b1;
        o_csr_write = 1'b1;
        o_csr_idx   = IDX_MCAUSE;
        o_csr_data  = {is_irq_q, 27'b0, code_q};
      end
      W_TVAL: begin
        o_csr_sel   = 1'b1;
        o_csr_write = 1'b1;
        o_csr_idx   = IDX_MTVAL;
        o_csr_data  = tval_q;
      end
      W_STATUS: begin
        o_csr_sel   = 1'b1;
        o_csr_write = 1'b1;
        o_csr_idx   = IDX_MSTATUS;
        o_csr_data  = entry_status(i_mstatus);
      end
      R_STATUS: begin
        o_csr_sel   = 1'b1;
        o_csr_write = 1'b1;
        o_csr_idx   = IDX_MSTATUS;
        o_csr_data  = mret_status(i_mstatus);
      end
      REDIR: begin
        o_redirect    = 1'b1;
        o_flush       = 1'b1;
        o_redirect_pc = i_trap_pc;
      end
      R_REDIR: begin
        o_redirect    = 1'b1;
        o_flush       = 1'b1;
        o_redirect_pc = i_mepc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      is_irq_q <= 1'b0;
      code_q   <= 4'h0;
      epc_q    <= 32'h0;
      tval_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      is_irq_q <= is_irq_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
    end
  end

endmodule

// File: doc/rv_trap_seq.md
Name: rv_trap_seq

Overview:
- Machine-mode trap sequencer; sits between the core pipeline and the machine CSR file.
- Arbitrates synchronous exceptions, MRET and the pending interrupts (external/soft/timer).
- Issues the ordered single-cycle CSR writes for trap entry and exit: mepc, mcause, mtval, mstatus.
- Then redirects and flushes the pipeline to the trap vector or to mepc.

Parameters:
- MTVAL_EN, 1: 1 = write mtval on trap entry; 0 = skip the mtval write state (entry is one cycle shorter).

Ports:
- i_clk  in  1  core clock; all state on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_irq_ext  in  1  machine external interrupt pending (level).
- i_irq_soft  in  1  machine software interrupt pending (level).
- i_irq_timer  in  1  machine timer interrupt pending (level).
- i_en_ext  in  1  mie.MEIE.
- i_en_soft  in  1  mie.MSIE.
- i_en_timer  in  1  mie.MTIE.
- i_mstatus  in  32  current mstatus read value.
- i_mepc  in  32  current mepc read value.
- i_trap_pc  in  32  trap target computed by CSR file from mtvec/mcause.
- i_boundary  in  1  pipeline at an instruction boundary where an interrupt may be taken.
- i_exc_valid  in  1  synchronous exception request.
- i_exc_code  in  4  exception cause code.
- i_exc_pc  in  32  PC of the faulting instruction.
- i_exc_tval  in  32  exception trap value.
- i_mret  in  1  MRET retiring.
- i_next_pc  in  32  PC of the next instruction (interrupt return address).
- o_stall  out  1  hold pipeline.
- o_flush  out  1  flush pipeline (one cycle).
- o_redirect  out  1  load o_redirect_pc into fetch (one cycle).
- o_redirect_pc  out  32  redirect target.
- o_csr_sel  out  1  CSR access strobe.
- o_csr_write  out  1  full-word write; set/clear are never used.
- o_csr_idx  out  8  CSR index: 0x00 mstatus, 0x41 mepc, 0x42 mcause, 0x43 mtval.
- o_csr_data  out  32  write data.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset=1 at a clock edge): state := IDLE; latched cause/pc/tval := 0; all outputs 0.
- Reset mid-sequence aborts immediately. CSR writes already issued are not rolled back.
- Priority in IDLE, evaluated combinationally each cycle:
  - exception (i_exc_valid) > i_mret > interrupt.
  - Interrupt condition: i_mstatus[3] & i_boundary & (pending & enable) for any source.
  - Interrupt priority: ext (code 11) > soft (code 3) > timer (code 7).
- o_stall = o_busy | (IDLE & any request accepted this cycle).
- Accept cycle T: latch the following, then go to W_EPC.
  - is_irq.
  - code: exception code, or irq code.
  - epc: i_exc_pc (exception) or i_next_pc (interrupt).
  - tval: i_exc_tval (exception) or 0 (interrupt).
- Trap entry FSM, exactly one CSR write per state, write with sel=1, write=1:
  - W_EPC: idx 0x41, data epc.
  - W_CAUSE: idx 0x42, data {is_irq, 27'b0, code}.
  - W_TVAL: idx 0x43, data tval. Skipped when MTVAL_EN=0.
  - W_STATUS: idx 0x00, data = i_mstatus sampled this cycle with bit7 (MPIE) := bit3 (MIE), bit3 := 0, bits[12:11] (MPP) := 2'b11, all other bits preserved.
  - REDIR: o_redirect=1, o_flush=1, o_redirect_pc=i_trap_pc, no CSR access; then IDLE.
- Entry timing with MTVAL_EN=1: writes at T+1..T+4, redirect at T+5. With MTVAL_EN=0: redirect at T+4.
- MRET FSM from accept cycle T:
  - R_STATUS (T+1): write idx 0x00, data = i_mstatus with bit3 := bit7, bit7 := 1, MPP := 2'b11.
  - R_REDIR (T+2): o_redirect=1, o_flush=1, o_redirect_pc=i_mepc; then IDLE.
- Outputs outside write/redirect states: o_csr_sel, o_csr_write, o_csr_idx, o_csr_data, o_redirect, o_flush are all 0. o_redirect_pc is 0 unless o_redirect=1.
- Requests while busy: all inputs are ignored while o_busy=1; no queuing. Upstream must hold or replay; stall guarantees no retirement.
- Same-cycle conflicts in IDLE: exception + mret + irq together → exception only. Interrupts stay pending and are re-evaluated in IDLE after return. They are blocked by MIE=0 after entry until MRET restores it.
- Interrupt de-asserting after accept does not cancel the sequence; the latched cause is used.
- Exception taken with MIE=0 is still taken; MPIE receives 0.

Test Plan:
1. Reset while in W_CAUSE → next cycle IDLE, o_busy=0, all outputs 0, no further CSR writes.
2. i_exc_valid=1, code=3, pc=0x100, tval=0x100, mstatus=0x8, trap_pc=0x200 → write sequence:
   - T+1: 0x41 ← 0x100.
   - T+2: 0x42 ← 0x3.
   - T+3: 0x43 ← 0x100.
   - T+4: 0x00 ← 0x1880.
   - T+5: redirect 0x200 with flush.
3. mstatus=0x8, i_boundary=1, all three irqs pending and enabled, next_pc=0x404 → mepc ← 0x404, mcause ← 0x8000000B, mtval ← 0; timer-only pending → mcause 0x80000007.
4. Irq pending+enabled but mstatus[3]=0 or i_boundary=0 → no accept, o_stall=0. Exception and irq in the same cycle → mcause=code, bit31=0.
5. i_mret=1, mstatus=0x1880, mepc=0x404 → T+1 write 0x00 ← 0x1888; T+2 redirect 0x404; new request during T+1 ignored.
6. MTVAL_EN=0, exception → no idx 0x43 write, redirect at T+4.
